// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a show-ahead byte FIFO.
// RX is synchronised and oversampled OVS times per bit. Each bit is decided by a
// 3-sample majority vote around mid-bit. Short start glitches are rejected, and a
// low stop bit discards the byte with a frame_err pulse.
module uart_rx_fifo #(
    parameter int DIV = 18,
    parameter int OVS = 12,
    parameter int AW  = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RX,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_en,
    output logic [AW:0] count,
    output logic        frame_err,
    output logic        overflow
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW    = $clog2(OVS);

    localparam logic [CW-1:0] FREQ_RELOAD = CW'(DIV - 1);
    localparam logic [OW-1:0] OVS_SAMP_LO = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] OVS_SAMP_MD = OW'(OVS / 2);
    localparam logic [OW-1:0] OVS_VOTE    = OW'(OVS / 2 + 1);
    localparam logic [OW-1:0] OVS_LAST    = OW'(OVS - 1);
    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   cnt_freq;
    logic [OW-1:0]   ovs_cnt;
    logic [2:0]      bit_idx;
    logic            samp_lo;
    logic            samp_md;
    logic [7:0]      shift_reg;
    logic            tick;
    logic            vote_tick;
    logic            bit_end;
    logic            vote;
    logic            push_req;
    logic            ferr_req;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            ovf_req;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign tick      = (state != IDLE) && (cnt_freq == '0);
    assign vote_tick = tick && (ovs_cnt == OVS_VOTE);
    assign bit_end   = tick && (ovs_cnt == OVS_LAST);
    // Third sample is taken live on the vote tick so the decision needs no extra cycle.
    assign vote      = maj3(samp_lo, samp_md, rxs);

    assign push_req  = (state == STOP) && vote_tick && vote;
    assign ferr_req  = (state == STOP) && vote_tick && !vote;
    assign full      = (count == FULL_CNT);
    assign pop       = rd_en && rd_valid;
    // A full FIFO still accepts a byte when a pop frees the slot in the same cycle.
    assign wr_en     = push_req && (!full || pop);
    assign ovf_req   = push_req && full && !pop;

    assign rd_valid  = (count != '0);
    assign rd_data   = mem[rd_ptr];

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    // Oversample tick divider and tick counter; both parked while the line is idle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_freq <= '0;
            ovs_cnt  <= '0;
        end else if (state == IDLE) begin
            cnt_freq <= FREQ_RELOAD;
            ovs_cnt  <= '0;
        end else begin
            cnt_freq <= (cnt_freq == '0) ? FREQ_RELOAD : cnt_freq - CW'(1);
            if (tick) begin
                ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OW'(1);
            end
        end
    end

    // Mid-bit samples and the LSB-first data shifter.
    always_ff @(posedge Clock) begin
        if (tick && (ovs_cnt == OVS_SAMP_LO)) begin
            samp_lo <= rxs;
        end
        if (tick && (ovs_cnt == OVS_SAMP_MD)) begin
            samp_md <= rxs;
        end
        if ((state == DATA) && vote_tick) begin
            shift_reg <= {vote, shift_reg[7:1]};
        end
    end

    // Receiver state register and data bit index.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            bit_idx <= '0;
        end else begin
            state <= state_nxt;
            if ((state == START) && bit_end) begin
                bit_idx <= '0;
            end else if ((state == DATA) && bit_end && (bit_idx != 3'd7)) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Next-state logic; STOP exits on the vote tick to leave half a bit for resync.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rxs) state_nxt = START;
            START: begin
                if (vote_tick && vote) state_nxt = IDLE;
                else if (bit_end)      state_nxt = DATA;
            end
            DATA:    if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:    if (vote_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Circular FIFO storage, pointers and occupancy, plus the registered error pulses.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= ferr_req;
            overflow  <= ovf_req;
            if (wr_en) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!wr_en && pop) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule
